// File: rtl/bam_seq.sv
// bam_seq: four-state register-file / data-RAM ALU sequencer (IDLE, READ, EXEC, WRITE).
// A host loads registers while the sequencer is idle. Each started operation reads two
// registers, runs one ALU op and commits the result to either a register or a RAM word.
// Optional feature macro: BAM_SEQ_OVF_EN enables the signed add/sub overflow flag (ovf).
// When the macro is undefined, ovf is tied to 0.
module bam_seq #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int RAM_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              dst_ram,
  input  logic [REG_AW-1:0] rd,
  input  logic [RAM_AW-1:0] ram_waddr,
  input  logic [RAM_AW-1:0] ram_raddr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              ovf,
  output logic [DATA_W-1:0] ram_rdata
);

  localparam int NUM_REGS  = 2**REG_AW;
  localparam int NUM_WORDS = 2**RAM_AW;
  localparam int SH_W      = $clog2(DATA_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]        state;

  logic [2:0]        op_q;
  logic [REG_AW-1:0] ra1_q;
  logic [REG_AW-1:0] ra2_q;
  logic              dst_ram_q;
  logic [REG_AW-1:0] rd_q;
  logic [RAM_AW-1:0] ram_waddr_q;

  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_out;

  // The register file is a packed vector so the whole file clears in a single assignment.
  logic [NUM_REGS-1:0][DATA_W-1:0] regfile;
  logic [DATA_W-1:0]               ram [NUM_WORDS];

  logic accept;
  logic load_ok;
  logic reg_we;
  logic ram_we;

  // Start wins over a simultaneous host load. Neither start nor load is honoured outside IDLE.
  assign accept  = (state == IDLE) && start;
  assign load_ok = (state == IDLE) && !start && ld_en;
  assign reg_we  = (state == WRITE) && !dst_ram_q;
  // RAM is never reset, so the commit is gated by rst explicitly to abort a write during reset.
  assign ram_we  = (state == WRITE) && dst_ram_q && !rst;

  assign busy = (state != IDLE);
  assign done = (state == WRITE);

  // Sequencer: a fixed walk READ -> EXEC -> WRITE once an operation is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= READ;
        READ:    state <= EXEC;
        EXEC:    state <= WRITE;
        default: state <= IDLE;
      endcase
    end
  end

  // Snapshot the operation fields on acceptance, so input changes while busy have no effect.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q        <= op;
      ra1_q       <= ra1;
      ra2_q       <= ra2;
      dst_ram_q   <= dst_ram;
      rd_q        <= rd;
      ram_waddr_q <= ram_waddr;
    end
  end

  // Read operands in READ, so an operation sees whatever the previous operation committed.
  always_ff @(posedge clk) begin
    if (state == READ) begin
      opa <= regfile[ra1_q];
      opb <= regfile[ra2_q];
    end
  end

  // ALU: all results wrap to DATA_W bits. Shift amount uses only the low log2(DATA_W) bits of B.
  always_comb begin
    alu_out = '0;
    case (op_q)
      3'b000:  alu_out = opa + opb;
      3'b001:  alu_out = opa - opb;
      3'b010:  alu_out = opa & opb;
      3'b011:  alu_out = opa | opb;
      3'b100:  alu_out = opa ^ opb;
      3'b101:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      3'b110:  alu_out = opa << opb[SH_W-1:0];
      default: alu_out = opa;
    endcase
  end

  // Register result and zero flag at the end of EXEC. Both hold until the next EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zf     <= 1'b0;
    end else if (state == EXEC) begin
      result <= alu_out;
      zf     <= (alu_out == '0);
    end
  end

`ifdef BAM_SEQ_OVF_EN
  logic ovf_next;

  // Signed overflow: operand signs are compatible but the sign of the sum/difference flipped.
  always_comb begin
    ovf_next = 1'b0;
    case (op_q)
      3'b000:  ovf_next = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_out[DATA_W-1] != opa[DATA_W-1]);
      3'b001:  ovf_next = (opa[DATA_W-1] != opb[DATA_W-1]) && (alu_out[DATA_W-1] != opa[DATA_W-1]);
      default: ovf_next = 1'b0;
    endcase
  end

  // Overflow flag follows the same EXEC-only update rule as result and zf.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == EXEC) begin
      ovf <= ovf_next;
    end
  end
`else
  assign ovf = 1'b0;
`endif

  // Register file: clears on reset. Host loads happen only in IDLE; commits happen only in WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      regfile <= '0;
    end else if (load_ok) begin
      regfile[ld_addr] <= ld_data;
    end else if (reg_we) begin
      regfile[rd_q] <= result;
    end
  end

  // Data RAM write port. Contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr_q] <= result;
    end
  end

  // Registered read port. A same-cycle write to the same word returns the previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rdata <= '0;
    end else begin
      ram_rdata <= ram[ram_raddr];
    end
  end

endmodule

// File: tb/tb_bam_seq.sv
// tb_bam_seq: scoreboard bench for bam_seq with a behavioural reference model.
// Expected results are queued at issue time. A negedge monitor pops and compares them on done.
// Expected ovf follows the BAM_SEQ_OVF_EN macro that the design is built with.
`timescale 1ns/1ps
module tb_bam_seq;

  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int RAM_AW    = 5;
  localparam int NUM_REGS  = 32;
  localparam int NUM_WORDS = 32;

`ifdef BAM_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              ld_en;
  logic [REG_AW-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              start;
  logic [2:0]        op;
  logic [REG_AW-1:0] ra1;
  logic [REG_AW-1:0] ra2;
  logic              dst_ram;
  logic [REG_AW-1:0] rd;
  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zf;
  logic              ovf;
  logic [DATA_W-1:0] ram_rdata;

  bam_seq #(.DATA_W(DATA_W), .REG_AW(REG_AW), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .op(op), .ra1(ra1), .ra2(ra2), .dst_ram(dst_ram), .rd(rd),
    .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .busy(busy), .done(done),
    .result(result), .zf(zf), .ovf(ovf), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_regs [NUM_REGS];
  logic [31:0] model_ram  [NUM_WORDS];
  bit          ram_known  [NUM_WORDS];
  int          vectors     = 0;
  int          miscompares = 0;
  int          done_seen   = 0;
  int          ops_issued  = 0;
  bit          mon_en      = 1'b0;
  logic [REG_AW-1:0] side_addr;
  logic [31:0]       side_data;
  logic [31:0]       old_word;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference ALU written from the opcode table using plain integer arithmetic.
  function automatic logic [31:0] model_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd6:    return a << (b % 32);
      default: return a;
    endcase
  endfunction

  // Overflow means the exact signed add/sub falls outside the 32-bit signed range.
  function automatic logic model_ovf(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint r;
    sa = $signed(a);
    sb = $signed(b);
    if (f == 3'd0)      r = sa + sb;
    else if (f == 3'd1) r = sa - sb;
    else                return 1'b0;
    return OVF_ON && ((r > 64'sh7FFF_FFFF) || (r < -64'sh8000_0000));
  endfunction

  task automatic loadReg(input logic [REG_AW-1:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    model_regs[a] = d;
  endtask

  // mode: 0 plain, 1 start/load disturbance while busy, 2 load alongside start, 3 reset in WRITE
  task automatic applyStimulus(input logic [2:0] f, input logic [REG_AW-1:0] a1, input logic [REG_AW-1:0] a2,
                               input logic to_ram, input logic [REG_AW-1:0] dst,
                               input logic [RAM_AW-1:0] waddr, input int mode);
    exp_t        e;
    logic [31:0] r;
    r     = model_alu(f, model_regs[a1], model_regs[a2]);
    e.res = r;
    e.zf  = (r == 32'd0);
    e.ovf = model_ovf(f, model_regs[a1], model_regs[a2]);
    exp_q.push_back(e);
    ops_issued++;
    op = f; ra1 = a1; ra2 = a2; dst_ram = to_ram; rd = dst; ram_waddr = waddr;
    start = 1'b1;
    if (mode == 2) begin
      ld_en = 1'b1; ld_addr = side_addr; ld_data = side_data;
    end
    @(posedge clk); #1;
    start = 1'b0;
    ld_en = 1'b0;
    if (mode == 1) begin
      start     = 1'b1;
      op        = 3'($urandom_range(7));
      ra1       = 5'($urandom_range(31));
      ra2       = 5'($urandom_range(31));
      dst_ram   = 1'($urandom_range(1));
      rd        = 5'($urandom_range(31));
      ram_waddr = 5'($urandom_range(31));
      ld_en     = 1'b1;
      ld_addr   = side_addr;
      ld_data   = side_data;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("busy_during_op", 32'(busy), 32'd1);
      checkOutput("done_timing", 32'(done), 32'(k == 2));
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        ld_en = 1'b0;
        if (mode == 3) rst = 1'b1;
      end
    end
    if (mode == 3) begin
      rst = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'd0;
    end else if (to_ram) begin
      model_ram[waddr] = r;
      ram_known[waddr] = 1'b1;
    end else begin
      model_regs[dst] = r;
    end
  endtask

  task automatic readReg(input logic [REG_AW-1:0] a);
    applyStimulus(3'd7, a, a, 1'b0, a, 5'd0, 0);
  endtask

  task automatic checkRam(input logic [RAM_AW-1:0] a);
    ram_raddr = a;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ram_rdata", ram_rdata, model_ram[a]);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done=1 expected done=0 (nothing pending)");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("result", result, mon_e.res);
        checkOutput("zf", 32'(zf), 32'(mon_e.zf));
        checkOutput("ovf", 32'(ovf), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish within 200us");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; op = '0;
    ra1 = '0; ra2 = '0; dst_ram = 1'b0; rd = '0; ram_waddr = '0; ram_raddr = '0;
    side_addr = '0; side_data = '0; old_word = '0;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'd0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      model_ram[i] = 32'd0;
      ram_known[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zf", 32'(zf), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_ram_rdata", ram_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    $display("[TB] reset released");

    readReg(5'd9);

    // r1=5, r2=7, r3 = r1 + r2
    loadReg(5'd1, 32'd5);
    loadReg(5'd2, 32'd7);
    applyStimulus(3'd0, 5'd1, 5'd2, 1'b0, 5'd3, 5'd0, 0);
    readReg(5'd3);

    // 9 - 9 into RAM[4]; the register file is untouched
    loadReg(5'd1, 32'd9);
    loadReg(5'd2, 32'd9);
    applyStimulus(3'd1, 5'd1, 5'd2, 1'b1, 5'd3, 5'd4, 0);
    checkRam(5'd4);
    readReg(5'd1);
    readReg(5'd3);

    // signed overflow on add and sub
    loadReg(5'd1, 32'h7FFF_FFFF);
    loadReg(5'd2, 32'd1);
    applyStimulus(3'd0, 5'd1, 5'd2, 1'b0, 5'd6, 5'd0, 0);
    loadReg(5'd7, 32'h8000_0000);
    applyStimulus(3'd1, 5'd7, 5'd2, 1'b0, 5'd8, 5'd0, 0);
    readReg(5'd8);

    // same-address RAM read during write returns old word, new word one cycle later
    old_word  = model_ram[4];
    ram_raddr = 5'd4;
    applyStimulus(3'd7, 5'd6, 5'd6, 1'b1, 5'd0, 5'd4, 0);
    @(negedge clk);
    checkOutput("ram_rdw_old", ram_rdata, old_word);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ram_rdw_new", ram_rdata, model_ram[4]);
    @(posedge clk); #1;

    // start and load while busy are both ignored
    loadReg(5'd10, 32'h0000_1234);
    loadReg(5'd11, 32'd3);
    side_addr = 5'd10;
    side_data = 32'hDEAD_BEEF;
    applyStimulus(3'd6, 5'd10, 5'd11, 1'b0, 5'd12, 5'd0, 1);
    readReg(5'd10);
    readReg(5'd12);
    checkOutput("done_count", 32'(done_seen), 32'(ops_issued));

    // load in the same IDLE cycle as start is dropped
    side_addr = 5'd13;
    side_data = 32'hCAFE_F00D;
    applyStimulus(3'd4, 5'd1, 5'd2, 1'b0, 5'd14, 5'd0, 2);
    readReg(5'd13);
    readReg(5'd14);

    // randomized mix of loads, operations and RAM readbacks
    for (int it = 0; it < 40; it++) begin
      logic [RAM_AW-1:0] wa;
      logic [31:0]       val;
      val = ($urandom_range(3) == 0) ? 32'($urandom_range(4)) : $urandom;
      if ($urandom_range(3) == 0) begin
        loadReg(5'($urandom_range(31)), val);
      end else begin
        wa = 5'($urandom_range(31));
        applyStimulus(3'($urandom_range(7)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                      1'($urandom_range(1)), 5'($urandom_range(31)), wa, 0);
        if (ram_known[wa]) checkRam(wa);
      end
    end

    // reset during WRITE aborts the commit and clears everything but RAM
    loadReg(5'd20, 32'h0000_0055);
    applyStimulus(3'd7, 5'd20, 5'd20, 1'b1, 5'd0, 5'd4, 3);
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_zf", 32'(zf), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    checkOutput("abort_ram_rdata", ram_rdata, 32'd0);
    @(posedge clk); #1;
    checkRam(5'd4);
    for (int r = 0; r < NUM_REGS; r++) readReg(5'(r));

    checkOutput("pending_ops", 32'(exp_q.size()), 32'd0);
    checkOutput("final_done_count", 32'(done_seen), 32'(ops_issued));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
